// File: rtl/dmem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_ctrl
// Purpose  : CPU-side controller for the data port of the shared
//            2-cycle-latency memory. Serialises loads and stores from the
//            MEM stage and follows the memory busy-counter handshake.
//            Load data comes back as a one-cycle response pulse.
// Option   : DMEM_WRITE_BUFFER_EN -- when defined, stores go into a
//            WB_DEPTH-entry FIFO and retire without waiting for memory.
// Ports    : clk, reset_n (sync, active-low)
//            i_req_valid/i_req_write/i_req_addr/i_req_wdata -> o_req_ready
//            o_resp_valid/o_resp_rdata : load response
//            o_idle                    : nothing in flight, buffer empty
//            o_mem_read/o_mem_write/o_mem_addr/io_mem_data/i_mem_ready
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_ctrl #(
  parameter int WORD     = 16,
  parameter int WB_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req_valid,
  input  logic            i_req_write,
  input  logic [WORD-1:0] i_req_addr,
  input  logic [WORD-1:0] i_req_wdata,
  output logic            o_req_ready,
  output logic            o_resp_valid,
  output logic [WORD-1:0] o_resp_rdata,
  output logic            o_idle,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic [WORD-1:0] o_mem_addr,
  inout  wire  [WORD-1:0] io_mem_data,
  input  logic            i_mem_ready
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_RD_WAIT = 2'd1;
  localparam logic [1:0] c_WR_WAIT = 2'd2;

  generate
    if (WB_DEPTH < 1) begin : g_bad_wb_depth
      $error("WB_DEPTH must be at least 1");
    end
  endgenerate

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [WORD-1:0] r_rd_addr;
  logic            r_resp_valid;
  logic [WORD-1:0] r_resp_rdata;

  logic            w_issue_ok;   // a new command may be placed on the port
  logic            w_ret;        // load return cycle
  logic            w_issue_rd;
  logic            w_issue_wr;
  logic [WORD-1:0] w_wr_addr;
  logic [WORD-1:0] w_wr_data;
  logic            w_req_ready;
  logic            w_wb_empty;

  // Everything that reaches the memory is gated by reset so strobes stay low
  // while reset_n is held, independent of the pre-reset state.
  assign w_issue_ok = reset_n && i_mem_ready &&
                      ((r_state == c_IDLE) || (r_state == c_WR_WAIT));
  assign w_ret      = reset_n && i_mem_ready && (r_state == c_RD_WAIT);

`ifdef DMEM_WRITE_BUFFER_EN
  localparam int          c_PW   = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam logic [c_PW:0]   c_FULL = (c_PW+1)'(WB_DEPTH);
  localparam logic [c_PW-1:0] c_LAST = c_PW'(WB_DEPTH - 1);

  logic [WORD-1:0] r_wb_addr [WB_DEPTH];
  logic [WORD-1:0] r_wb_data [WB_DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW:0]   r_count;
  logic            w_wb_full;
  logic            w_enq;
  logic            w_deq;

  assign w_wb_empty = (r_count == '0);
  // Full is judged on the registered count: a same-cycle dequeue does not
  // free a slot for the store presented in that cycle.
  assign w_wb_full  = (r_count == c_FULL);
  assign w_enq      = reset_n && i_req_valid && i_req_write && !w_wb_full;
  assign w_deq      = w_issue_ok && !w_wb_empty;

  // The head drains before any load; loads wait for an empty buffer, which
  // keeps program order without forwarding.
  assign w_issue_wr = w_deq;
  assign w_issue_rd = w_issue_ok && w_wb_empty && i_req_valid && !i_req_write;
  assign w_wr_addr  = r_wb_addr[r_rd_ptr];
  assign w_wr_data  = r_wb_data[r_rd_ptr];
  assign w_req_ready = i_req_write ? !w_wb_full : (w_issue_ok && w_wb_empty);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wb_addr[r_wr_ptr] <= i_req_addr;
        r_wb_data[r_wr_ptr] <= i_req_wdata;
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + 1'b1;
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - 1'b1;
      end
    end
  end
`else
  assign w_wb_empty  = 1'b1;
  assign w_issue_wr  = w_issue_ok && i_req_valid && i_req_write;
  assign w_issue_rd  = w_issue_ok && i_req_valid && !i_req_write;
  assign w_wr_addr   = i_req_addr;
  assign w_wr_data   = i_req_wdata;
  assign w_req_ready = w_issue_ok;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE, c_WR_WAIT: begin
        if (w_issue_rd) begin
          w_next_state = c_RD_WAIT;
        end else if (w_issue_wr) begin
          w_next_state = c_WR_WAIT;
        end else if (i_mem_ready) begin
          w_next_state = c_IDLE;
        end
      end
      c_RD_WAIT: begin
        if (i_mem_ready) begin
          w_next_state = c_IDLE;
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output logic. mem_read is re-asserted in the return cycle so the memory
  // presents the data; the dummy read it starts is simply never consumed.
  always_comb begin
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_addr  = '0;
    if (w_ret) begin
      o_mem_read = 1'b1;
      o_mem_addr = r_rd_addr;
    end else if (w_issue_rd) begin
      o_mem_read = 1'b1;
      o_mem_addr = i_req_addr;
    end else if (w_issue_wr) begin
      o_mem_write = 1'b1;
      o_mem_addr  = w_wr_addr;
    end
    o_req_ready  = reset_n && w_req_ready;
    o_idle       = (r_state == c_IDLE) && w_wb_empty;
    o_resp_valid = r_resp_valid;
    o_resp_rdata = r_resp_rdata;
  end

  assign io_mem_data = o_mem_write ? w_wr_data : {WORD{1'bz}};

  // Load address and response registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_addr    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= w_ret;
      if (w_issue_rd) begin
        r_rd_addr <= i_req_addr;
      end
      if (w_ret) begin
        r_resp_rdata <= io_mem_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_port_ctrl.md
# dmem_port_ctrl

CPU-side controller for the data port of the shared 2-cycle-latency memory. It sits between the CPU's MEM stage and the memory's data interface: `mem_read`, `mem_write`, `mem_addr`, the inout `mem_data` and `mem_ready`. It serialises load and store requests, obeys the memory's busy-counter handshake and returns load data to the pipeline. An optional store buffer lets stores retire without waiting for memory.

## Interface
- `WORD`, default 16, data and address width.
- `WB_DEPTH`, default 2, store-buffer entries; used only with `DMEM_WRITE_BUFFER_EN`.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset: synchronous, active-low.
- `req_valid`  in  1  MEM stage presents a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  WORD  word address.
- `req_wdata`  in  WORD  store data.
- `req_ready`  out  1  request accepted this cycle when `req_valid` is also high.
- `resp_valid`  out  1  one-cycle pulse; `resp_rdata` is valid.
- `resp_rdata`  out  WORD  load data, held until the next response.
- `idle`  out  1  no access in flight and store buffer empty.
- `mem_read`, `mem_write`  out  1  memory command strobes.
- `mem_addr`  out  WORD  memory address.
- `mem_data`  inout  WORD  driven with store data while `mem_write` is high; high-Z otherwise.
- `mem_ready`  in  1  memory counter is 0.

## Operation
- States: IDLE, RD_WAIT, WR_WAIT.
- **Issue condition:** command issue is allowed when the state is IDLE, or WR_WAIT with `mem_ready` = 1, and `mem_ready` = 1.
- **Issuing a command:** the controller drives `mem_read` or `mem_write`, `mem_addr` and `mem_data` combinationally from the request, or from the store-buffer head. The memory samples them at the next edge.
- **Load**
  - Issue: `mem_read` = 1 with `req_addr`, `req_ready` = 1; go to RD_WAIT.
  - RD_WAIT while `mem_ready` = 0: all strobes low.
  - RD_WAIT with `mem_ready` = 1 (return cycle): assert `mem_read` and `mem_addr` again, capture `mem_data` into `resp_rdata`, pulse `resp_valid` next cycle, go to IDLE.
  - Asserting `mem_read` in the return cycle causes a trailing dummy read in the memory. The controller therefore keeps `mem_read` low afterwards and waits for `mem_ready` before the next issue. No data is consumed from the dummy read.
- **Store (no buffer)**
  - Issue: `mem_write` = 1 with address and data, `req_ready` = 1; go to WR_WAIT.
  - WR_WAIT: when `mem_ready` = 1, the next command may issue in the same cycle.
- `req_ready` = 0 whenever the issue condition fails.
- `idle` = state IDLE, and buffer empty when the buffer is compiled in.
- **Reset:** state IDLE, all strobes 0, `mem_addr` 0, `mem_data` high-Z, `req_ready` 0 during reset, `resp_valid` 0, `resp_rdata` 0, buffer empty. Reset mid-access abandons it with no response. The memory resets its counter on the same edge.

## Timing
- **Load** accepted in cycle 0:
  - `mem_ready` low in cycles 1–2.
  - Return cycle 3.
  - `resp_valid` in cycle 4.
  - `mem_ready` low in cycles 4–5 (dummy read).
  - Next issue possible in cycle 6.
- **Store** accepted in cycle 0: memory writes at the end of cycle 2; next issue possible in cycle 3.
- Load-to-use latency is 4 cycles; load throughput is one load every 6 cycles; store throughput is one store every 3 cycles.
- `resp_valid` is exactly one cycle wide and never asserts for stores.

## Configuration
- `DMEM_WRITE_BUFFER_EN` defined:
  - Stores enter a FIFO of `WB_DEPTH` entries. `req_ready` = 1 for a store whenever the buffer is not full, regardless of memory state.
  - A full buffer blocks the store even if an entry dequeues in the same cycle.
  - The buffer head issues under the issue condition and is dequeued at that edge. A store enqueued in cycle n issues no earlier than cycle n+1.
  - A load is accepted only when the buffer is empty and the issue condition holds. There is no forwarding, and program order is preserved.
  - The buffer pointers wrap modulo `WB_DEPTH`.
- `DMEM_WRITE_BUFFER_EN` undefined: no buffer logic exists, and stores behave as described under Operation.

## Test plan
- Preload mem[0x0002] = 0xFFFF; load addr 0x0002 accepted in cycle 0 -> `resp_valid` in cycle 4 with `resp_rdata` = 0xFFFF; `req_ready` = 0 in cycles 1–5 and 1 in cycle 6.
- Store 0x1234 to 0x00F0 in cycle 0, then load 0x00F0 -> the load is accepted in cycle 3 and returns 0x1234 in cycle 7; `mem_data` is high-Z in every cycle except 0.
- Two back-to-back stores with no buffer -> accepted in cycles 0 and 3; mem[0x10] = 0xAAAA and mem[0x11] = 0x5555 afterwards.
- Reset asserted in cycle 2 of a load -> no `resp_valid`, all outputs at their reset values, and a new load after reset returns correct data.
- With `DMEM_WRITE_BUFFER_EN` and `WB_DEPTH` = 2, stores A, B, C, D presented from cycle 0 -> accepted in cycles 0, 1, 2 and 5; `idle` rises after D's write completes; memory holds all four values.
- With the buffer enabled, a load presented right after two buffered stores -> `req_ready` stays 0 until the buffer is empty and `mem_ready` = 1, and the load returns the second store's data when the addresses match.
